armleocpu_decode: RTL

//  Decode stage of the 3-stage pipeline, between armleocpu_fetch (F2D/D2F) and execute (D2E/E2D).

---
 rtl/armleocpu_decode.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/armleocpu_decode.sv
// Decode stage: one-entry D2E register, register address extraction, serialization stall.
// Define ARMLEOCPU_DECODE_ILLEGAL_EN to flag and serialize unsupported opcodes.

`ifndef F2E_TYPE_WIDTH
`define F2E_TYPE_WIDTH 2
`endif
`ifndef F2E_TYPE_INSTR
`define F2E_TYPE_INSTR 2'd0
`endif
`ifndef F2E_TYPE_INTERRUPT_PENDING
`define F2E_TYPE_INTERRUPT_PENDING 2'd1
`endif
`ifndef ARMLEOCPU_D2F_CMD_WIDTH
`define ARMLEOCPU_D2F_CMD_WIDTH 2
`endif
`ifndef ARMLEOCPU_D2F_CMD_NONE
`define ARMLEOCPU_D2F_CMD_NONE 2'd0
`endif
`ifndef ARMLEOCPU_D2F_CMD_START_BRANCH
`define ARMLEOCPU_D2F_CMD_START_BRANCH 2'd1
`endif
`ifndef ARMLEOCPU_D2F_CMD_FLUSH
`define ARMLEOCPU_D2F_CMD_FLUSH 2'd2
`endif

module armleocpu_decode #(
    parameter logic SERIALIZE_FENCE = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst_n,

    input  logic                                f2d_valid,
    input  logic [`F2E_TYPE_WIDTH-1:0]          f2d_type,
    input  logic [31:0]                         f2d_instr,
    input  logic [31:0]                         f2d_pc,

    output logic                                d2f_ready,
    output logic [`ARMLEOCPU_D2F_CMD_WIDTH-1:0] d2f_cmd,
    output logic [31:0]                         d2f_branchtarget,

    output logic                                d2e_valid,
    output logic [`F2E_TYPE_WIDTH-1:0]          d2e_type,
    output logic [31:0]                         d2e_instr,
    output logic [31:0]                         d2e_pc,
    output logic [4:0]                          d2e_rs1_addr,
    output logic [4:0]                          d2e_rs2_addr,
    output logic [4:0]                          d2e_rd_addr,
    output logic                                d2e_serialize,
    output logic                                d2e_illegal,

    input  logic                                e2d_ready,
    input  logic [`ARMLEOCPU_D2F_CMD_WIDTH-1:0] e2d_cmd,
    input  logic [31:0]                         e2d_branchtarget
);

    typedef enum logic {
        IDLE,
        SERIALIZE
    } state_t;

    state_t state;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_instr;
    logic       is_system;
    logic       is_fence;
    logic       is_fence_i;
    logic       f2d_illegal;
    logic       f2d_serialize;
    logic       redirect;
    logic       load;

    assign opcode   = f2d_instr[6:0];
    assign funct3   = f2d_instr[14:12];
    assign is_instr = (f2d_type == `F2E_TYPE_INSTR);

    assign is_system  = (opcode == 7'b1110011);
    assign is_fence   = (opcode == 7'b0001111) && (funct3 == 3'b000);
    assign is_fence_i = (opcode == 7'b0001111) && (funct3 == 3'b001);

`ifdef ARMLEOCPU_DECODE_ILLEGAL_EN
    // Full 7-bit opcode match also rejects compressed encodings (instr[1:0] != 2'b11).
    always_comb begin
        f2d_illegal = 1'b0;
        if (is_instr) begin
            case (opcode)
                7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                7'b0110011, 7'b0001111, 7'b1110011: f2d_illegal = 1'b0;
                default:                            f2d_illegal = 1'b1;
            endcase
        end
    end
`else
    assign f2d_illegal = 1'b0;
`endif

    assign f2d_serialize = (f2d_type == `F2E_TYPE_INTERRUPT_PENDING)
                        || (is_instr && (is_system || is_fence_i
                                         || (SERIALIZE_FENCE && is_fence)
                                         || f2d_illegal));

    assign redirect = (e2d_cmd != `ARMLEOCPU_D2F_CMD_NONE);

    // Redirects pass straight through to fetch; outputs are held quiet while in reset.
    always_comb begin
        d2f_ready        = 1'b0;
        d2f_cmd          = `ARMLEOCPU_D2F_CMD_NONE;
        d2f_branchtarget = '0;
        if (rst_n) begin
            if (redirect) begin
                d2f_ready        = 1'b1;
                d2f_cmd          = e2d_cmd;
                d2f_branchtarget = e2d_branchtarget;
            end else begin
                d2f_ready = (state == IDLE) && (!d2e_valid || e2d_ready);
            end
        end
    end

    assign load = f2d_valid && d2f_ready && !redirect;

    assign d2e_rs1_addr = d2e_instr[19:15];
    assign d2e_rs2_addr = d2e_instr[24:20];
    assign d2e_rd_addr  = d2e_instr[11:7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            d2e_valid     <= 1'b0;
            d2e_type      <= `F2E_TYPE_INSTR;
            d2e_instr     <= '0;
            d2e_pc        <= '0;
            d2e_serialize <= 1'b0;
            d2e_illegal   <= 1'b0;
        end else if (redirect) begin
            d2e_valid <= 1'b0;
            if (e2d_cmd == `ARMLEOCPU_D2F_CMD_START_BRANCH)
                state <= IDLE;
        end else if (load) begin
            d2e_valid     <= 1'b1;
            d2e_type      <= f2d_type;
            d2e_instr     <= f2d_instr;
            d2e_pc        <= f2d_pc;
            d2e_serialize <= f2d_serialize;
            d2e_illegal   <= f2d_illegal;
            if (f2d_serialize)
                state <= SERIALIZE;
        end else if (e2d_ready && d2e_valid) begin
            d2e_valid <= 1'b0;
        end
    end

endmodule
